// File: rtl/muldiv_seq_unit_pkg.sv
// muldiv_seq_unit_pkg: funct codes, FSM state and step-mode encodings shared by the multiply/divide unit
package muldiv_seq_unit_pkg;
   localparam logic [5:0] MFHI_FUNCT  = 6'h10;
   localparam logic [5:0] MTHI_FUNCT  = 6'h11;
   localparam logic [5:0] MFLO_FUNCT  = 6'h12;
   localparam logic [5:0] MTLO_FUNCT  = 6'h13;
   localparam logic [5:0] MULT_FUNCT  = 6'h18;
   localparam logic [5:0] MULTU_FUNCT = 6'h19;
   localparam logic [5:0] DIV_FUNCT   = 6'h1a;
   localparam logic [5:0] DIVU_FUNCT  = 6'h1b;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_e;
   typedef enum logic {MODE_MUL, MODE_DIV} mode_e;
   function automatic logic is_muldiv(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction
endpackage

// File: rtl/muldiv_seq_unit_if.sv
// muldiv_seq_unit_if: request/result bundle between the EX stage and the multiply/divide unit
interface muldiv_seq_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             op_valid;
   logic             op_ready;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (
      output op_valid, funct, rs_val, rt_val, flush,
      input  op_ready, busy, done, hi, lo
   );
   modport slave (
      input  op_valid, funct, rs_val, rt_val, flush,
      output op_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step import muldiv_seq_unit_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  mode_e            mode,
   input  logic [2*WIDTH:0] acc_in,
   input  logic [WIDTH:0]   operand,
   output logic [2*WIDTH:0] acc_out,
   output logic             q_bit
);
   logic [2*WIDTH:0] sh;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   sum;
   // divide leaves the quotient bit slot at zero; the caller inserts q_bit
   always_comb begin
      sh      = {acc_in[2*WIDTH-1:0], 1'b0};
      rem_sh  = sh[2*WIDTH:WIDTH];
      q_bit   = mode == MODE_DIV && rem_sh >= operand;
      sum     = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? operand : '0);
      acc_out = mode == MODE_DIV ? (q_bit ? {rem_sh - operand, sh[WIDTH-1:0]} : sh)
                                 : {1'b0, sum, acc_in[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes
module muldiv_seq_unit import muldiv_seq_unit_pkg::*; #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst_n,
   muldiv_seq_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   state_e             state, state_nxt;
   mode_e              mode;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   acc, step_acc;
   logic [WIDTH:0]     opb;
   logic               neg_q, neg_r, div_zero, q_bit, accept, start, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b, quot, rem, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode    (mode),
      .acc_in  (acc),
      .operand (opb),
      .acc_out (step_acc),
      .q_bit   (q_bit)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   always_comb
      state_nxt = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE)
                : (state == ST_RUN && !bus.flush) ? (cnt == CNT_W'(1) ? ST_FIN : ST_RUN)
                : ST_IDLE;
   always_comb begin
      bus.op_ready = state == ST_IDLE && !bus.flush;
      bus.busy     = state != ST_IDLE;
      bus.done     = state == ST_FIN && !bus.flush;
   end
   // signed ops work on magnitudes; the sign is restored at commit time
   always_comb begin
      accept = bus.op_valid && bus.op_ready;
      start  = accept && is_muldiv(bus.funct);
      sa     = !bus.funct[0] && bus.rs_val[WIDTH-1];
      sb     = !bus.funct[0] && bus.rt_val[WIDTH-1];
      mag_a  = sa ? -bus.rs_val : bus.rs_val;
      mag_b  = sb ? -bus.rt_val : bus.rt_val;
      prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
      quot   = acc[WIDTH-1:0];
      rem    = acc[2*WIDTH-1:WIDTH];
      res_hi = mode == MODE_DIV ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
      res_lo = mode == MODE_DIV ? (div_zero ? '1 : neg_q ? -quot : quot) : prod[WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mode     <= MODE_MUL;
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         bus.hi   <= '0;
         bus.lo   <= '0;
      end else begin
         if (start) begin
            mode     <= bus.funct[1] ? MODE_DIV : MODE_MUL;
            cnt      <= CNT_W'(WIDTH);
            acc      <= (2*WIDTH+1)'(mag_a);
            opb      <= {1'b0, mag_b};
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            div_zero <= bus.funct[1] && bus.rt_val == '0;
         end else if (state == ST_RUN) begin
            acc <= {step_acc[2*WIDTH:1], mode == MODE_DIV ? q_bit : step_acc[0]};
            cnt <= cnt - CNT_W'(1);
         end
         bus.hi <= (accept && bus.funct == MTHI_FUNCT) ? bus.rs_val : bus.done ? res_hi : bus.hi;
         bus.lo <= (accept && bus.funct == MTLO_FUNCT) ? bus.rs_val : bus.done ? res_lo : bus.lo;
      end
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: directed vectors for the 32-bit and 8-bit multiply/divide unit
module tb_muldiv_seq_unit;
   import muldiv_seq_unit_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   muldiv_seq_unit_if #(.WIDTH(32)) bus32 ();
   muldiv_seq_unit_if #(.WIDTH(8))  bus8 ();
   muldiv_seq_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   muldiv_seq_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus32.op_valid = 1'b1;
      bus32.funct    = f;
      bus32.rs_val   = a;
      bus32.rt_val   = b;
      @(posedge clk);
      #1 bus32.op_valid = 1'b0;
   endtask

   task automatic wait32(output int lat, output int low);
      lat = -1;
      low = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus32.done && lat < 0) lat = k;
         if (bus32.op_ready) break;
         low++;
      end
   endtask

   task automatic op32(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat, low;
      @(negedge clk);
      send32(f, a, b);
      wait32(lat, low);
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check({tag, "_hi"}, 64'(bus32.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus32.lo), 64'(exp_lo));
   endtask

   task automatic op8(input string tag, input logic [5:0] f, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
      int lat = -1;
      @(negedge clk);
      bus8.op_valid = 1'b1;
      bus8.funct    = f;
      bus8.rs_val   = a;
      bus8.rt_val   = b;
      @(posedge clk);
      #1 bus8.op_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus8.done && lat < 0) lat = k;
         if (bus8.op_ready) break;
      end
      check({tag, "_lat"}, 64'(lat), 64'd9);
      check({tag, "_hi"}, 64'(bus8.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus8.lo), 64'(exp_lo));
   endtask

   initial begin
      int lat, low;
      logic seen;
      bus32.op_valid = 1'b0; bus32.funct = '0; bus32.rs_val = '0; bus32.rt_val = '0; bus32.flush = 1'b0;
      bus8.op_valid  = 1'b0; bus8.funct  = '0; bus8.rs_val  = '0; bus8.rt_val  = '0; bus8.flush  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus32.busy), 64'd0);
      check("rst_done", 64'(bus32.done), 64'd0);
      check("rst_hi", 64'(bus32.hi), 64'd0);
      check("rst_lo", 64'(bus32.lo), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 64'(bus32.op_ready), 64'd1);

      op32("mult", MULT_FUNCT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      op32("multu", MULTU_FUNCT, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
      op32("div", DIV_FUNCT, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op32("divu", DIVU_FUNCT, 32'd7, 32'd2, 32'd1, 32'd3);
      op32("div_ovf", DIV_FUNCT, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      op32("divu_z", DIVU_FUNCT, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
      op32("div_z", DIV_FUNCT, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
      op32("div_neg", DIV_FUNCT, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

      // MTLO then MULT on consecutive edges
      @(negedge clk);
      send32(MTLO_FUNCT, 32'hABCD, 32'd0);
      check("mtlo_lo", 64'(bus32.lo), 64'hABCD);
      check("mtlo_busy", 64'(bus32.busy), 64'd0);
      send32(MULT_FUNCT, 32'd5, 32'd6);
      wait32(lat, low);
      check("b2b_lat", 64'(lat), 64'd33);
      check("b2b_rdy_low", 64'(low), 64'd33);
      check("b2b_hi", 64'(bus32.hi), 64'd0);
      check("b2b_lo", 64'(bus32.lo), 64'd30);

      // unrecognised funct leaves HI/LO alone and stays idle
      @(negedge clk);
      send32(6'h12, 32'h5555, 32'h6666);
      check("bad_busy", 64'(bus32.busy), 64'd0);
      check("bad_lo", 64'(bus32.lo), 64'd30);

      // flush in IDLE rejects a same-cycle MTHI
      @(negedge clk);
      bus32.flush = 1'b1;
      bus32.op_valid = 1'b1; bus32.funct = MTHI_FUNCT; bus32.rs_val = 32'hDEAD;
      #1 check("flush_idle_rdy", 64'(bus32.op_ready), 64'd0);
      @(posedge clk);
      #1 bus32.flush = 1'b0; bus32.op_valid = 1'b0;
      check("flush_idle_hi", 64'(bus32.hi), 64'd0);

      // flush at cycle 10 of a DIV
      @(negedge clk);
      send32(DIV_FUNCT, 32'd100, 32'd7);
      seen = 1'b0;
      repeat (9) begin
         @(negedge clk);
         seen |= bus32.done;
      end
      @(negedge clk);
      bus32.flush = 1'b1;
      @(posedge clk);
      #1 bus32.flush = 1'b0;
      @(negedge clk);
      check("flush_run_rdy", 64'(bus32.op_ready), 64'd1);
      check("flush_run_busy", 64'(bus32.busy), 64'd0);
      repeat (40) begin
         @(negedge clk);
         seen |= bus32.done;
      end
      check("flush_run_done", 64'(seen), 64'd0);
      check("flush_run_hi", 64'(bus32.hi), 64'd0);
      check("flush_run_lo", 64'(bus32.lo), 64'd30);

      // flush during FIN suppresses the commit
      @(negedge clk);
      send32(MULTU_FUNCT, 32'h10, 32'h10);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = bus32.done;
      end
      check("fin_reached", 64'(seen), 64'd1);
      bus32.flush = 1'b1;
      #1 check("fin_flush_done", 64'(bus32.done), 64'd0);
      @(posedge clk);
      #1 bus32.flush = 1'b0;
      @(negedge clk);
      check("fin_flush_busy", 64'(bus32.busy), 64'd0);
      check("fin_flush_lo", 64'(bus32.lo), 64'd30);
      op32("after_flush", DIVU_FUNCT, 32'd7, 32'd2, 32'd1, 32'd3);

      op8("w8_mult", MULT_FUNCT, 8'h80, 8'h80, 8'h40, 8'h00);
      op8("w8_div_ovf", DIV_FUNCT, 8'h80, 8'hFF, 8'h00, 8'h80);
      op8("w8_divu_z", DIVU_FUNCT, 8'h64, 8'h00, 8'h64, 8'hFF);
      op8("w8_multu", MULTU_FUNCT, 8'hFF, 8'hFF, 8'hFE, 8'h01);

      // async reset mid-RUN of a MULT
      @(negedge clk);
      send32(MTHI_FUNCT, 32'h5A5A, 32'd0);
      send32(MULT_FUNCT, 32'd3, 32'd4);
      repeat (5) @(negedge clk);
      check("mid_busy_pre", 64'(bus32.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(bus32.busy), 64'd0);
      check("mid_rst_hi", 64'(bus32.hi), 64'd0);
      check("mid_rst_lo", 64'(bus32.lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_rdy", 64'(bus32.op_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= bus32.done;
      end
      check("mid_rst_done", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
